// File: rtl/sdram_tester_pkg.sv
// Shared types and constants for the SDRAM pattern tester: FSM states, pattern
// mode codes, LFSR tap masks and the base seed.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_DRAIN,
    ST_CHECKED,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_NADDR = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  localparam logic [15:0] BASE_SEED = 16'hACE1;

  // Right-shift Galois masks; common widths are maximal-length.
  function automatic logic [63:0] lfsr_taps(input int dw);
    case (dw)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_A300_0000;
      64:      return 64'hD800_0000_0000_0000;
      default: return (64'd1 << (dw - 1)) | (64'd1 << (dw - 2));
    endcase
  endfunction

  // Narrow data widths get the 16-bit seed XOR-folded onto DW bits.
  function automatic logic [63:0] fold_seed(input int dw);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s[i % dw] = s[i % dw] ^ BASE_SEED[i];
    return s;
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Pattern word generator: address-derived patterns are combinational, the LFSR
// pattern advances one state per step and restarts from seed on load.
module sdram_pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] seed,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    mode,
  output logic [DW-1:0] word
);

  localparam logic [DW-1:0] TAPS  = DW'(lfsr_taps(DW));
  localparam logic [DW-1:0] SEED0 = DW'(fold_seed(DW));

  logic [DW-1:0] lfsr_q;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED0;
    end else if (load) begin
      lfsr_q <= (seed == '0) ? DW'(1) : seed;
    end else if (step) begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_comb begin
    word = '0;
    case (mode)
      MODE_ADDR:  word = DW'(addr);
      MODE_NADDR: word = ~DW'(addr);
      MODE_WALK:  word = DW'(1) << (int'(addr) % DW);
      default:    word = lfsr_q;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM FIFO self-test engine: write DEPTH pattern words, wait, read back and
// compare. Optional first-failure log enabled by SDRAM_TESTER_ERRLOG_EN.
module sdram_pattern_tester
  import sdram_tester_pkg::*;
#(
  parameter  int DW      = 16,
  parameter  int DEPTH   = 1024,
  parameter  int RD_LAT  = 1,
  parameter  int GAP_CYC = 256,
  parameter  int ERRW    = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iSTART,
  input  logic [1:0]      iMODE,
  input  logic            iLOOP,
  input  logic            iWR_FULL,
  input  logic            iRD_EMPTY,
  output logic            oWRITE,
  output logic [DW-1:0]   oWRITEDATA,
  output logic            oREAD,
  input  logic [DW-1:0]   iREADDATA,
  output logic            oBUSY,
  output logic            oDONE,
  output logic            oPASS,
  output logic            oFAIL,
  output logic [ERRW-1:0] oERR_CNT,
  output logic [15:0]     oPASS_CNT,
`ifdef SDRAM_TESTER_ERRLOG_EN
  output logic [AW-1:0]   oFAIL_ADDR,
  output logic [DW-1:0]   oFAIL_EXP,
  output logic [DW-1:0]   oFAIL_GOT,
`endif
  output state_t          dbg_state
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [DW-1:0] SEED0 = DW'(fold_seed(DW));

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [GW-1:0]   gap_q;
  logic [2:0]      drain_q;
  logic [1:0]      mode_q;
  logic            loop_q;
  logic [DW-1:0]   seed_q, seed_d;
  logic            start_ok, last_addr, wr_load, rd_load, mismatch;
  logic [DW-1:0]   wr_word, exp_word;
  logic [DW-1:0]   exp_pipe [RD_LAT];
  logic            vld_pipe [RD_LAT];
  logic            pass_q, fail_q;
  logic [ERRW-1:0] err_q;
  logic [15:0]     pcnt_q;

  // Handshake: oWRITE/oREAD are valid strobes and !iWR_FULL/!iRD_EMPTY are the
  // matching ready; ready is folded in combinationally, so each high strobe
  // cycle is exactly one transferred word.
  assign oWRITE     = (state_q == ST_WRITE) && !iWR_FULL;
  assign oREAD      = (state_q == ST_READ) && !iRD_EMPTY;
  assign oWRITEDATA = (state_q == ST_WRITE) ? wr_word : '0;
  assign oBUSY      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign oDONE      = (state_q == ST_DONE);
  assign oPASS      = pass_q;
  assign oFAIL      = fail_q;
  assign oERR_CNT   = err_q;
  assign oPASS_CNT  = pcnt_q;
  assign dbg_state  = state_q;

  assign start_ok  = iSTART && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_addr = (addr_q == AW'(DEPTH - 1));
  assign mismatch  = vld_pipe[RD_LAT-1] && (exp_pipe[RD_LAT-1] != iREADDATA);

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    wr_load = 1'b0;
    rd_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (iSTART) begin
        state_d = ST_WRITE;
        seed_d  = SEED0;
        wr_load = 1'b1;
      end
      ST_WRITE: if (oWRITE && last_addr) state_d = ST_GAP;
      ST_GAP: if (gap_q == GW'(GAP_CYC - 1)) begin
        state_d = ST_READ;
        rd_load = 1'b1;
      end
      ST_READ:  if (oREAD && last_addr) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == 3'(RD_LAT - 1)) state_d = ST_CHECKED;
      ST_CHECKED: if (loop_q) begin
        state_d = ST_WRITE;
        seed_d  = seed_q + DW'(1);
        wr_load = 1'b1;
      end else begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      gap_q   <= '0;
      drain_q <= '0;
      mode_q  <= '0;
      loop_q  <= 1'b0;
      seed_q  <= SEED0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      if (start_ok) begin
        mode_q <= iMODE;
        loop_q <= iLOOP;
      end
      // Every phase change restarts the word address at zero.
      if (state_d != state_q) addr_q <= '0;
      else if (oWRITE || oREAD) addr_q <= addr_q + AW'(1);
      gap_q   <= (state_q == ST_GAP) ? gap_q + GW'(1) : '0;
      drain_q <= (state_q == ST_DRAIN) ? drain_q + 3'd1 : '0;
    end
  end

  sdram_pattern_gen #(.DW(DW), .AW(AW)) u_wr_gen (
    .clk  (iCLK),
    .rst  (iRST),
    .load (wr_load),
    .step (oWRITE),
    .seed (seed_d),
    .addr (addr_q),
    .mode (mode_q),
    .word (wr_word)
  );

  sdram_pattern_gen #(.DW(DW), .AW(AW)) u_exp_gen (
    .clk  (iCLK),
    .rst  (iRST),
    .load (rd_load),
    .step (oREAD),
    .seed (seed_q),
    .addr (addr_q),
    .mode (mode_q),
    .word (exp_word)
  );

  // Expected word travels alongside the read so the tap lines up with iREADDATA.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < RD_LAT; i++) begin
        exp_pipe[i] <= '0;
        vld_pipe[i] <= 1'b0;
      end
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      err_q  <= '0;
      pcnt_q <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        exp_pipe[i] <= exp_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
      exp_pipe[0] <= exp_word;
      vld_pipe[0] <= oREAD;
      if (start_ok) begin
        pass_q <= 1'b0;
        fail_q <= 1'b0;
        err_q  <= '0;
        pcnt_q <= '0;
      end else begin
        if (mismatch) begin
          fail_q <= 1'b1;
          if (err_q != '1) err_q <= err_q + ERRW'(1);
        end
        if (state_q == ST_CHECKED) begin
          pass_q <= !fail_q;
          pcnt_q <= pcnt_q + 16'd1;
        end
      end
    end
  end

`ifdef SDRAM_TESTER_ERRLOG_EN
  logic [AW-1:0] addr_pipe [RD_LAT];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < RD_LAT; i++) addr_pipe[i] <= '0;
      oFAIL_ADDR <= '0;
      oFAIL_EXP  <= '0;
      oFAIL_GOT  <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) addr_pipe[i] <= addr_pipe[i-1];
      addr_pipe[0] <= addr_q;
      if (start_ok) begin
        oFAIL_ADDR <= '0;
        oFAIL_EXP  <= '0;
        oFAIL_GOT  <= '0;
      end else if (mismatch && !fail_q) begin
        oFAIL_ADDR <= addr_pipe[RD_LAT-1];
        oFAIL_EXP  <= exp_pipe[RD_LAT-1];
        oFAIL_GOT  <= iREADDATA;
      end
    end
  end
`else
  // Without the log, mismatches only feed oFAIL and oERR_CNT.
`endif

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester (DW=16, DEPTH=16, RD_LAT=3) with a FIFO/SDRAM
// memory model, a write-data scoreboard and table-driven single-pass vectors.
module tb_sdram_pattern_tester;
  import sdram_tester_pkg::*;

  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int RD_LAT = 3;

  logic clk;
  logic rst, start, loop_in, wr_full, rd_empty;
  logic [1:0] mode_in;
  logic wr, rd, busy, done, pass, fail;
  logic [DW-1:0] wdata, rdata;
  logic [15:0] err_cnt, pass_cnt;
  state_t dbg_state;
`ifdef SDRAM_TESTER_ERRLOG_EN
  logic [3:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_got;
`endif

  sdram_pattern_tester #(
    .DW(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .GAP_CYC(8), .ERRW(16)
  ) u_dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iSTART     (start),
    .iMODE      (mode_in),
    .iLOOP      (loop_in),
    .iWR_FULL   (wr_full),
    .iRD_EMPTY  (rd_empty),
    .oWRITE     (wr),
    .oWRITEDATA (wdata),
    .oREAD      (rd),
    .iREADDATA  (rdata),
    .oBUSY      (busy),
    .oDONE      (done),
    .oPASS      (pass),
    .oFAIL      (fail),
    .oERR_CNT   (err_cnt),
    .oPASS_CNT  (pass_cnt),
`ifdef SDRAM_TESTER_ERRLOG_EN
    .oFAIL_ADDR (fail_addr),
    .oFAIL_EXP  (fail_exp),
    .oFAIL_GOT  (fail_got),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];
  int wr_ptr, rd_ptr;
  bit flip, block_writes;

  always @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
    end else begin
      if (wr) begin
        if (!block_writes) mem[wr_ptr] <= wdata;
        wr_ptr <= (wr_ptr + 1) % DEPTH;
      end
      if (rd) begin
        rd_pipe[0] <= mem[rd_ptr] ^ ((flip && rd_ptr == 5) ? 16'h0008 : 16'h0000);
        rd_ptr <= (rd_ptr + 1) % DEPTH;
      end else begin
        rd_pipe[0] <= 16'hDEAD;
      end
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rdata = rd_pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_tests, n_fail, n_wr, n_rd, pass_idx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_pass(input logic [1:0] m, input int p);
    logic [15:0] l;
    l = 16'hACE1 + 16'(p);
    for (int a = 0; a < DEPTH; a++) begin
      case (m)
        2'd0:    exp_q.push_back(16'(a));
        2'd1:    exp_q.push_back(~16'(a));
        2'd2:    exp_q.push_back(16'd1 << a);
        default: exp_q.push_back(l);
      endcase
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic monitor(input logic [1:0] m);
    logic [DW-1:0] w;
    if (wr) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        push_pass(m, pass_idx);
        pass_idx++;
      end
      w = exp_q.pop_front();
      check("wdata", 32'(wdata), 32'(w));
    end
    if (rd) n_rd++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic begin_run(input logic [1:0] m, input bit lp);
    exp_q.delete();
    pass_idx = 0;
    n_wr = 0;
    n_rd = 0;
    @(negedge clk);
    mode_in = m;
    loop_in = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    loop_in = 1'b0;
    mode_in = ~m;  // must not affect the running pass
  endtask

  task automatic drive_throttle(input int fm, input int em, input int cyc);
    wr_full  = (fm == 1) ? cyc[0] : (fm == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    rd_empty = (em == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    int         full_mode;   // 0 never, 1 every other cycle, 2 random
    int         empty_mode;  // 0 never, 1 random
    bit         flip;
    bit         exp_pass;
    int         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic run_pass(input vec_t v);
    int cyc;
    flip = v.flip;
    block_writes = 1'b0;
    begin_run(v.mode, 1'b0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      drive_throttle(v.full_mode, v.empty_mode, cyc);
      #1;
      monitor(v.mode);
      @(negedge clk);
      cyc++;
    end
    wr_full = 1'b0;
    rd_empty = 1'b0;
    check("pass_timeout", 32'(cyc < 2000), 32'd1);
    check("done", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("writes", 32'(n_wr), 32'(DEPTH));
    check("reads", 32'(n_rd), 32'(DEPTH));
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("pass", 32'(pass), 32'(v.exp_pass));
    check("fail", 32'(fail), 32'(!v.exp_pass));
    check("err_cnt", 32'(err_cnt), 32'(v.exp_err));
`ifdef SDRAM_TESTER_ERRLOG_EN
    if (v.flip) begin
      check("fail_addr", 32'(fail_addr), 32'd5);
      check("fail_xor", 32'(fail_got ^ fail_exp), 32'h0008);
    end
`endif
  endtask

  task automatic loop_run(input bit stale);
    int cyc, target;
    flip = 1'b0;
    block_writes = 1'b0;
    target = stale ? 2 : 3;
    begin_run(2'd3, 1'b1);
    cyc = 0;
    while (pass_cnt < 16'(target) && cyc < 3000) begin
      if (stale && pass_cnt == 16'd1) block_writes = 1'b1;
      #1;
      monitor(2'd3);
      @(negedge clk);
      cyc++;
    end
    check("loop_timeout", 32'(cyc < 3000), 32'd1);
    check("loop_pass_cnt", 32'(pass_cnt), 32'(target));
    check("loop_busy", 32'(busy), 32'd1);
    check("loop_pass", 32'(pass), 32'(!stale));
    check("loop_fail", 32'(fail), 32'(stale));
    check("loop_err_cnt", 32'(err_cnt), stale ? 32'd16 : 32'd0);
    block_writes = 1'b0;
    do_reset();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    loop_in = 1'b0;
    mode_in = 2'd0;
    wr_full = 1'b0;
    rd_empty = 1'b0;
    flip = 1'b0;
    block_writes = 1'b0;

    vecs[0] = '{mode: 2'd0, full_mode: 0, empty_mode: 0, flip: 1'b0, exp_pass: 1'b1, exp_err: 0};
    vecs[1] = '{mode: 2'd1, full_mode: 1, empty_mode: 0, flip: 1'b0, exp_pass: 1'b1, exp_err: 0};
    vecs[2] = '{mode: 2'd2, full_mode: 0, empty_mode: 1, flip: 1'b0, exp_pass: 1'b1, exp_err: 0};
    vecs[3] = '{mode: 2'd3, full_mode: 2, empty_mode: 1, flip: 1'b0, exp_pass: 1'b1, exp_err: 0};
    vecs[4] = '{mode: 2'd3, full_mode: 0, empty_mode: 0, flip: 1'b1, exp_pass: 1'b0, exp_err: 1};
    vecs[5] = '{mode: 2'd0, full_mode: 1, empty_mode: 1, flip: 1'b1, exp_pass: 1'b0, exp_err: 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_write", 32'(wr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_read", 32'(rd), 32'd0);
    check("rst_flags", 32'({busy, done, pass, fail}), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_pass_cnt", 32'(pass_cnt), 32'd0);

    for (int i = 0; i < 6; i++) run_pass(vecs[i]);

    loop_run(1'b0);
    loop_run(1'b1);

    // Reset in the middle of the read phase after a mismatch has been counted.
    flip = 1'b1;
    begin_run(2'd0, 1'b0);
    cyc = 0;
    while (err_cnt == 16'd0 && cyc < 500) begin
      #1;
      monitor(2'd0);
      @(negedge clk);
      cyc++;
    end
    check("mid_timeout", 32'(cyc < 500), 32'd1);
    check("mid_in_read", 32'(dbg_state), 32'(ST_READ));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_ignored_state", 32'(dbg_state), 32'(ST_READ));
    check("start_ignored_err", 32'(err_cnt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_read", 32'(rd), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_fail", 32'(fail), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef SDRAM_TESTER_ERRLOG_EN
    check("mid_rst_log", 32'(fail_addr), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_pass(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
